// File: rtl/modport_ram.sv
// modport_ram: single-port synchronous RAM
// registered read data, synchronous clear on reset
module modport_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  we_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L =
    (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  in_range;
  logic                  do_wr;
  logic                  do_rd;

  // decode the access requested this cycle
  always_comb begin
    in_range = ({1'b0, addr} < DEPTH_L);
    do_wr    = enable & we_en & in_range;
    do_rd    = enable & ~we_en;
  end

  // storage array: cleared on reset, written when enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_wr) begin
      mem[addr] <= data_in;
    end
  end

  // read register: holds across writes and idle cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
    end else if (do_rd) begin
      data_out <= in_range ? mem[addr] : '0;
    end
  end

endmodule

// File: tb/tb_modport_ram.sv
// tb_modport_ram: scoreboard bench for modport_ram
// expected data_out queued per cycle, popped after the edge
module tb_modport_ram;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       we_en;
  logic [3:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q [$];
  logic [7:0] m [16];
  logic [7:0] mo;

  always #5 clk = ~clk;

  modport_ram dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .we_en    (we_en),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  task automatic cyc(input logic r, input logic e,
                     input logic w, input logic [3:0] a,
                     input logic [7:0] d, input string tag);
    reset   = r;
    enable  = e;
    we_en   = w;
    addr    = a;
    data_in = d;
    if (r) begin
      for (int i = 0; i < 16; i++) m[i] = 8'h00;
      mo = 8'h00;
    end else if (e && w) begin
      m[a] = d;
    end else if (e) begin
      mo = m[a];
    end
    exp_q.push_back(mo);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      chk(tag, data_out, exp_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    mo = 8'h00;
    for (int i = 0; i < 16; i++) m[i] = 8'h00;
    reset = 1'b1; enable = 1'b0; we_en = 1'b0;
    addr = '0; data_in = '0;
    @(posedge clk);
    #1;

    cyc(1, 1, 1, 4'd5, 8'hEE, "rst");
    cyc(1, 0, 0, 4'd0, 8'h00, "rst2");

    for (int i = 0; i < 16; i++)
      cyc(0, 1, 0, 4'(i), 8'h00, "rd_zero");

    cyc(0, 1, 1, 4'd3, 8'hA5, "wr3_hold");
    cyc(0, 1, 0, 4'd3, 8'h00, "rd3");

    for (int i = 0; i < 16; i++)
      cyc(0, 1, 1, 4'(i), 8'(i * 17), "wr_fill");
    for (int i = 0; i < 16; i++)
      cyc(0, 1, 0, 4'(i), 8'h00, "rd_fill");

    cyc(0, 1, 1, 4'd2, 8'h5A, "wr2");
    cyc(0, 1, 0, 4'd2, 8'h00, "rd2_5a");
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 1, 4'd7, 8'hFF, "idle_hold");
    cyc(0, 1, 0, 4'd7, 8'h00, "rd7_prior");

    cyc(0, 1, 1, 4'd9, 8'h3C, "wr9");
    cyc(0, 1, 0, 4'd9, 8'h00, "rd9_3c");
    cyc(1, 1, 1, 4'd9, 8'h77, "rst_mid");
    cyc(0, 1, 0, 4'd9, 8'h00, "rd9_post");

    cyc(0, 1, 1, 4'd15, 8'h81, "wr15");
    cyc(0, 1, 1, 4'd0, 8'h7E, "wr0");
    cyc(0, 1, 0, 4'd15, 8'h00, "rd15");
    cyc(0, 1, 0, 4'd0, 8'h00, "rd0");

    cyc(0, 0, 0, 4'd15, 8'h00, "idle_rd");

    for (int i = 0; i < 60; i++)
      cyc(0, 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)),
          8'($urandom_range(0, 255)), "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/modport_ram.md
MODPORT_RAM -- requirements
Module: modport_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, address width in bits.
REQ-003 Parameter DEPTH, default 2**ADDR_WIDTH (16), number of words.
REQ-004 The block SHALL have exactly one clock and one reset: clk is the clock, and reset is synchronous and active-high.
REQ-005 Port clk  input  1  clock; all state SHALL update on its rising edge.
REQ-006 Port reset  input  1  synchronous active-high reset.
REQ-007 Port enable  input  1  access enable; no access occurs when it is low.
REQ-008 Port we_en  input  1  write enable; 1 = write, 0 = read; it is only qualified by enable.
REQ-009 Port addr  input  ADDR_WIDTH  word address.
REQ-010 Port data_in  input  DATA_WIDTH  write data.
REQ-011 Port data_out  output  DATA_WIDTH  registered read data.

Function
REQ-012 Storage SHALL be a single-port array of DEPTH words of DATA_WIDTH bits.
REQ-013 Write: at a rising clk edge with reset=0, enable=1 and we_en=1, mem[addr] SHALL take data_in.
REQ-014 A write SHALL NOT change data_out; there is no write-through.
REQ-015 Read: at a rising clk edge with reset=0, enable=1 and we_en=0, data_out SHALL take mem[addr].
REQ-016 Read latency SHALL be 1 cycle: data_out is valid immediately after the edge that samples the read request.
REQ-017 Idle: with enable=0, memory SHALL be unchanged and data_out SHALL hold its last value, regardless of we_en, addr and data_in.
REQ-018 Back-to-back accesses SHALL be supported every cycle with no stall.
REQ-019 A read in the cycle after a write to the same address SHALL return the newly written data.
REQ-020 Any addr value in 0..DEPTH-1 is legal. When DEPTH < 2**ADDR_WIDTH, an out-of-range write SHALL be ignored and an out-of-range read SHALL return 0.
REQ-021 There is no handshake, valid or error signalling; every enabled cycle completes exactly one access.

Reset
REQ-022 Reset is synchronous: at a rising clk edge with reset=1, data_out SHALL become 0 and every memory word SHALL become 0.
REQ-023 Reset SHALL take priority over enable and we_en; an access requested in a reset cycle SHALL be discarded.
REQ-024 Reset asserted mid-sequence SHALL discard all prior contents, and the first access after reset deassertion SHALL behave normally.
REQ-025 Outputs are undefined before the first reset edge; a bench SHALL apply reset for at least 1 clk cycle before checking.

Verification
REQ-026 Reset, then read addr 0..15 -> data_out = 8'h00 for every address, each one cycle after its request.
REQ-027 Write addr 3 = 8'hA5, then read addr 3 next cycle -> data_out = 8'hA5 one cycle later; data_out unchanged during the write cycle.
REQ-028 Write addr i = i*16+i for i = 0..15, then read all -> data_out = 8'h00, 8'h11, ... 8'hFF in order, one per cycle.
REQ-029 After data_out = 8'h5A, hold enable=0 with we_en=1, addr=7, data_in=8'hFF for 3 cycles, then read addr 7 -> data_out holds 8'h5A while idle, and the read returns the prior mem[7] (not 8'hFF).
REQ-030 Write addr 9 = 8'h3C, assert reset 1 cycle with enable=1, we_en=1, addr=9, data_in=8'h77, then read addr 9 -> data_out = 8'h00 after reset, and the read returns 8'h00.
REQ-031 Write addr 15 = 8'h81 and addr 0 = 8'h7E, then read 15 then 0 back-to-back -> data_out = 8'h81 then 8'h7E on consecutive cycles, confirming no address aliasing at the boundaries.
